// File: rtl/spi_arbiter.sv
// ---------------------------------------------------------------------------
// spi_arbiter
//
// Purpose:
//   Shares one spi_master between two requesters. Requests are arbitrated
//   round-robin in IDLE. The winner's write word is handed to the master,
//   the transfer is tracked until the master reports ready again, and the
//   owner then receives a one-cycle done pulse with the received word.
//
// Ports:
//   clk, rst            system clock; synchronous active-high reset
//   req0/req1           requester transfer requests (level)
//   wdata0/wdata1       requester write words
//   gnt0/gnt1           one-cycle grant pulses (write word latched)
//   done0/done1         one-cycle completion pulses (rdata/err valid)
//   rdata               last received word, shared by both requesters
//   err                 transfer aborted by the watchdog (qualified by done)
//   busy                high whenever the FSM is not in IDLE
//   spi_data_valid      to spi_master data_valid
//   spi_wdata           to spi_master WDATA
//   spi_rdy_bsyn        from spi_master status (1 = ready, 0 = busy)
//   spi_rdata           from spi_master RDATA
//
// Configuration:
//   SPI_ARB_TIMEOUT_EN  when defined, a watchdog aborts any transfer that
//                       spends TIMEOUT_CYCLES cycles in LAUNCH/XFER.
//                       When undefined, err is tied low and the FSM waits
//                       on the master indefinitely.
// ---------------------------------------------------------------------------
module spi_arbiter #(
    parameter int DW             = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy,
    output logic          spi_data_valid,
    output logic [DW-1:0] spi_wdata,
    input  logic          spi_rdy_bsyn,
    input  logic [DW-1:0] spi_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        XFER,
        RESP
    } state_t;

    state_t        state_q;
    logic          ptr_q;
    logic          owner_q;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          done0_q;
    logic          done1_q;
    logic          busy_q;
    logic          dataValid_q;
    logic [DW-1:0] spiWdata_q;
    logic [DW-1:0] rdata_q;

    // Winner selection: a lone requester always wins; on a tie the
    // priority pointer decides.
    logic          winner_d;
    logic [DW-1:0] winData_d;

    assign winner_d  = (req0 && req1) ? ptr_q : req1;
    assign winData_d = winner_d ? wdata1 : wdata0;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] wdCnt_q;
    logic          err_q;
    logic          wdExpired_d;

    // The counter starts at 0 on the first LAUNCH cycle, so expiry at
    // TIMEOUT_CYCLES-1 means the transfer has used TIMEOUT_CYCLES cycles.
    assign wdExpired_d = (wdCnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign err         = err_q;
`else
    assign err = 1'b0;
`endif

    // Single FSM with all outputs registered. Grant and done pulses are
    // cleared every cycle and only set on the edge that enters the state
    // in which they must be visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            dataValid_q <= 1'b0;
            spiWdata_q  <= '0;
            rdata_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            wdCnt_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;

`ifdef SPI_ARB_TIMEOUT_EN
            // Free-running while a transfer is in flight; cleared again on
            // LAUNCH entry by the IDLE branch below.
            if (state_q == LAUNCH || state_q == XFER) begin
                wdCnt_q <= wdCnt_q + 1'b1;
            end
`endif

            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q     <= LAUNCH;
                        busy_q      <= 1'b1;
                        dataValid_q <= 1'b1;
                        spiWdata_q  <= winData_d;
                        owner_q     <= winner_d;
                        ptr_q       <= ~winner_d;
                        if (winner_d) begin
                            gnt1_q <= 1'b1;
                        end else begin
                            gnt0_q <= 1'b1;
                        end
`ifdef SPI_ARB_TIMEOUT_EN
                        wdCnt_q <= '0;
`endif
                    end
                end

                // data_valid stays up until the master shows it has taken
                // the word by going busy.
                LAUNCH: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    if (wdExpired_d) begin
                        dataValid_q <= 1'b0;
                        state_q     <= RESP;
                        err_q       <= 1'b1;
                        rdata_q     <= '0;
                        if (owner_q) begin
                            done1_q <= 1'b1;
                        end else begin
                            done0_q <= 1'b1;
                        end
                    end else
`endif
                    if (!spi_rdy_bsyn) begin
                        dataValid_q <= 1'b0;
                        state_q     <= XFER;
                    end
                end

                // rdata tracks the master's output while it is busy, so the
                // value left behind is the last busy-cycle sample.
                XFER: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    if (wdExpired_d) begin
                        state_q <= RESP;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        if (owner_q) begin
                            done1_q <= 1'b1;
                        end else begin
                            done0_q <= 1'b1;
                        end
                    end else
`endif
                    if (spi_rdy_bsyn) begin
                        state_q <= RESP;
`ifdef SPI_ARB_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        if (owner_q) begin
                            done1_q <= 1'b1;
                        end else begin
                            done0_q <= 1'b1;
                        end
                    end else begin
                        rdata_q <= spi_rdata;
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    dataValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0           = gnt0_q;
    assign gnt1           = gnt1_q;
    assign done0          = done0_q;
    assign done1          = done1_q;
    assign busy           = busy_q;
    assign spi_data_valid = dataValid_q;
    assign spi_wdata      = spiWdata_q;
    assign rdata          = rdata_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_arbiter
//
// Purpose:
//   Directed, table-driven bench for spi_arbiter. Each vector gives the
//   inputs for one clock cycle and the outputs expected just after the
//   following rising edge. The spi_master side is driven directly from the
//   vectors (spi_rdy_bsyn / spi_rdata).
//
// Configuration:
//   SPI_ARB_TIMEOUT_EN  selects the watchdog-abort sequence; otherwise the
//                       bench checks that LAUNCH waits for 1000 cycles.
// ---------------------------------------------------------------------------
module tb_spi_arbiter;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       req1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] rdata;
    logic       err;
    logic       busy;
    logic       spi_data_valid;
    logic [7:0] spi_wdata;
    logic       spi_rdy_bsyn;
    logic [7:0] spi_rdata;

    int checks = 0;
    int errors = 0;

    // ctl = {rst, req0, req1, spi_rdy_bsyn}
    // flg = {gnt0, gnt1, done0, done1, busy, spi_data_valid, err}
    typedef struct {
        string      name;
        logic [3:0] ctl;
        logic [7:0] wd0;
        logic [7:0] wd1;
        logic [7:0] srd;
        logic [6:0] flg;
        logic [7:0] swd;
        logic [7:0] rd;
    } vec_t;

    vec_t vq[$];

    spi_arbiter #(
        .DW(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .req1(req1),
        .wdata0(wdata0),
        .wdata1(wdata1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .done0(done0),
        .done1(done1),
        .rdata(rdata),
        .err(err),
        .busy(busy),
        .spi_data_valid(spi_data_valid),
        .spi_wdata(spi_wdata),
        .spi_rdy_bsyn(spi_rdy_bsyn),
        .spi_rdata(spi_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the clock-driven sequence.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] time limit");
    end

    task automatic addv(input string nm, input logic [3:0] ctl,
                        input logic [7:0] wd0, input logic [7:0] wd1,
                        input logic [7:0] srd, input logic [6:0] flg,
                        input logic [7:0] swd, input logic [7:0] rd);
        vec_t v;
        v.name = nm; v.ctl = ctl; v.wd0 = wd0; v.wd1 = wd1; v.srd = srd;
        v.flg = flg; v.swd = swd; v.rd = rd;
        vq.push_back(v);
    endtask

    task automatic checkField(input string vname, input string fld,
                              input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", vname, fld, act, exp);
        end
    endtask

    // Inputs change on the falling edge, well away from the sampling edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst          = v.ctl[3];
        req0         = v.ctl[2];
        req1         = v.ctl[1];
        spi_rdy_bsyn = v.ctl[0];
        wdata0       = v.wd0;
        wdata1       = v.wd1;
        spi_rdata    = v.srd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        checkField(v.name, "gnt0",  {7'd0, gnt0},           {7'd0, v.flg[6]});
        checkField(v.name, "gnt1",  {7'd0, gnt1},           {7'd0, v.flg[5]});
        checkField(v.name, "done0", {7'd0, done0},          {7'd0, v.flg[4]});
        checkField(v.name, "done1", {7'd0, done1},          {7'd0, v.flg[3]});
        checkField(v.name, "busy",  {7'd0, busy},           {7'd0, v.flg[2]});
        checkField(v.name, "dv",    {7'd0, spi_data_valid}, {7'd0, v.flg[1]});
        checkField(v.name, "err",   {7'd0, err},            {7'd0, v.flg[0]});
        checkField(v.name, "swd",   spi_wdata,              v.swd);
        checkField(v.name, "rdata", rdata,                  v.rd);
    endtask

    task automatic runQueue();
        foreach (vq[i]) begin
            applyStimulus(vq[i]);
            checkOutput(vq[i]);
        end
        vq.delete();
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; spi_rdy_bsyn = 1'b1;
        wdata0 = '0; wdata1 = '0; spi_rdata = '0;

        // Single transfer from requester 0; req1 pulses while busy and
        // must be ignored.
        addv("rst0", 4'b1001, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00);
        addv("a0",   4'b0101, 8'hA5, 8'h00, 8'h00, 7'b1000110, 8'hA5, 8'h00);
        addv("a1",   4'b0001, 8'hA5, 8'h00, 8'h00, 7'b0000110, 8'hA5, 8'h00);
        addv("a2",   4'b0010, 8'hA5, 8'h99, 8'h11, 7'b0000100, 8'hA5, 8'h00);
        addv("a3",   4'b0000, 8'hA5, 8'h00, 8'h3C, 7'b0000100, 8'hA5, 8'h3C);
        addv("a4",   4'b0001, 8'hA5, 8'h00, 8'h3C, 7'b0010100, 8'hA5, 8'h3C);
        addv("a5",   4'b0001, 8'hA5, 8'h00, 8'h00, 7'b0000000, 8'hA5, 8'h3C);
        addv("a6",   4'b0001, 8'hA5, 8'h00, 8'h00, 7'b0000000, 8'hA5, 8'h3C);
        // Simultaneous requests after reset: 0 first, then 1 on the next
        // tie, then 0 again.
        addv("rst1", 4'b1001, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00);
        addv("b0",   4'b0111, 8'h11, 8'h22, 8'h00, 7'b1000110, 8'h11, 8'h00);
        addv("b1",   4'b0010, 8'h11, 8'h22, 8'h44, 7'b0000100, 8'h11, 8'h00);
        addv("b2",   4'b0010, 8'h11, 8'h22, 8'h44, 7'b0000100, 8'h11, 8'h44);
        addv("b3",   4'b0011, 8'h11, 8'h22, 8'h00, 7'b0010100, 8'h11, 8'h44);
        addv("b4",   4'b0111, 8'h77, 8'h22, 8'h00, 7'b0000000, 8'h11, 8'h44);
        addv("b5",   4'b0111, 8'h77, 8'h22, 8'h00, 7'b0100110, 8'h22, 8'h44);
        addv("b6",   4'b0100, 8'h77, 8'h22, 8'h66, 7'b0000100, 8'h22, 8'h44);
        addv("b7",   4'b0100, 8'h77, 8'h22, 8'h66, 7'b0000100, 8'h22, 8'h66);
        addv("b8",   4'b0101, 8'h77, 8'h22, 8'h00, 7'b0001100, 8'h22, 8'h66);
        addv("b9",   4'b0101, 8'h77, 8'h22, 8'h00, 7'b0000000, 8'h22, 8'h66);
        addv("b10",  4'b0101, 8'h77, 8'h22, 8'h00, 7'b1000110, 8'h77, 8'h66);
        addv("b11",  4'b0000, 8'h77, 8'h22, 8'h99, 7'b0000100, 8'h77, 8'h66);
        addv("b12",  4'b0001, 8'h77, 8'h22, 8'h99, 7'b0010100, 8'h77, 8'h66);
        addv("b13",  4'b0001, 8'h77, 8'h22, 8'h00, 7'b0000000, 8'h77, 8'h66);
        runQueue();

        // Master never goes busy: watchdog abort, or an indefinite wait.
        addv("t0",   4'b0101, 8'hE7, 8'h00, 8'h00, 7'b1000110, 8'hE7, 8'h66);
`ifdef SPI_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            addv("twait", 4'b0001, 8'hE7, 8'h00, 8'h00, 7'b0000110, 8'hE7, 8'h66);
        end
        addv("tabort", 4'b0001, 8'hE7, 8'h00, 8'h00, 7'b0010101, 8'hE7, 8'h00);
        addv("tidle",  4'b0001, 8'hE7, 8'h00, 8'h00, 7'b0000001, 8'hE7, 8'h00);
        addv("n0",     4'b0101, 8'hE7, 8'h00, 8'h00, 7'b1000111, 8'hE7, 8'h00);
        addv("n1",     4'b0000, 8'hE7, 8'h00, 8'h21, 7'b0000101, 8'hE7, 8'h00);
        addv("n2",     4'b0001, 8'hE7, 8'h00, 8'h00, 7'b0010100, 8'hE7, 8'h00);
        addv("n3",     4'b0001, 8'hE7, 8'h00, 8'h00, 7'b0000000, 8'hE7, 8'h00);
`else
        for (int i = 0; i < 1000; i++) begin
            addv("twait", 4'b0001, 8'hE7, 8'h00, 8'h00, 7'b0000110, 8'hE7, 8'h66);
        end
`endif
        runQueue();

        // req1 held across three back-to-back transfers: each grant is
        // preceded by exactly one idle cycle.
        addv("rst2", 4'b1001, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            addv("c_gnt",  4'b0011, 8'h00, 8'h5A, 8'h00, 7'b0100110, 8'h5A, 8'h00);
            addv("c_xfer", 4'b0010, 8'h00, 8'h5A, 8'h00, 7'b0000100, 8'h5A, 8'h00);
            addv("c_done", 4'b0011, 8'h00, 8'h5A, 8'h00, 7'b0001100, 8'h5A, 8'h00);
            addv("c_idle", 4'b0011, 8'h00, 8'h5A, 8'h00, 7'b0000000, 8'h5A, 8'h00);
        end
        runQueue();

        // Reset in the middle of XFER: everything clears, no done pulse,
        // then a fresh request is served normally.
        addv("rst3", 4'b1001, 8'h00, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00);
        addv("d0",   4'b0101, 8'hC3, 8'h00, 8'h00, 7'b1000110, 8'hC3, 8'h00);
        addv("d1",   4'b0000, 8'hC3, 8'h00, 8'h12, 7'b0000100, 8'hC3, 8'h00);
        addv("d2",   4'b0000, 8'hC3, 8'h00, 8'h34, 7'b0000100, 8'hC3, 8'h34);
        addv("d3",   4'b1000, 8'hC3, 8'h00, 8'h34, 7'b0000000, 8'h00, 8'h00);
        addv("d4",   4'b0001, 8'hC3, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00);
        addv("d5",   4'b0001, 8'hC3, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00);
        addv("d6",   4'b0101, 8'hC3, 8'h00, 8'h00, 7'b1000110, 8'hC3, 8'h00);
        addv("d7",   4'b0000, 8'hC3, 8'h00, 8'h56, 7'b0000100, 8'hC3, 8'h00);
        addv("d8",   4'b0001, 8'hC3, 8'h00, 8'h00, 7'b0010100, 8'hC3, 8'h00);
        addv("d9",   4'b0001, 8'hC3, 8'h00, 8'h00, 7'b0000000, 8'hC3, 8'h00);
        runQueue();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
